// File: rtl/gray_sync_rx_pkg.sv
// Shared types and helpers for the gray-code pointer receiver.
// gray_to_bin works on a fixed 32-bit word, and the mask limits it to the active width.
package gray_sync_rx_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    typedef enum logic [0:0] {
        StWarmup,
        StRun
    } state_e;

    function automatic logic [31:0] gray_to_bin(input logic [31:0] gray, input logic [31:0] mask);
        logic [31:0] g;
        logic [31:0] b;
        g     = gray & mask;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b & mask;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_sync_rx_if.sv
// Bus bundle between the gray receiver and the logic that consumes it.
interface gray_sync_rx_if #(
    parameter int unsigned WIDTH = 8
);

    logic [WIDTH-1:0] gray_in;
    logic             err_clr;
    logic [WIDTH-1:0] gray_sync;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] delta;
    logic             changed;
    logic             err_multibit;
    logic             err_sticky;
    logic             ready;

    modport master (
        output gray_in, err_clr,
        input  gray_sync, bin_out, delta, changed, err_multibit, err_sticky, ready
    );

    modport slave (
        input  gray_in, err_clr,
        output gray_sync, bin_out, delta, changed, err_multibit, err_sticky, ready
    );

endinterface

// File: rtl/gray_sync_rx_chain.sv
// Plain WIDTH x SYNC_STAGES flop synchronizer with no logic between stages.
// It is kept as its own module so that CDC constraints can name it directly.
module gray_sync_chain #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_rx.sv
// Receives a gray-coded pointer from a foreign domain and produces its binary value,
// a change pulse with the modulo step, and a multi-bit error flag.
module gray_sync_rx #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          nrst,
    gray_sync_rx_if.slave bus
);

    import gray_sync_rx_pkg::*;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("gray_sync_rx: SYNC_STAGES out of range");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("gray_sync_rx: WIDTH out of range");
    end

    localparam logic [31:0] Mask = 32'hFFFF_FFFF >> (32 - WIDTH);
    localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0] w_gray_sync;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_prev_bin;
    logic [5:0]       w_diff_bits;

    state_e           r_state_q, w_state_d;
    logic [CntW-1:0]  r_cnt_q, w_cnt_d;
    logic [WIDTH-1:0] r_prev_q, w_prev_d;
    logic [WIDTH-1:0] r_bin_q;
    logic [WIDTH-1:0] r_delta_q, w_delta_d;
    logic             r_changed_q, w_changed_d;
    logic             r_err_q, w_err_d;
    logic             r_sticky_q, w_sticky_d;
    logic             r_ready_q, w_ready_d;

    gray_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_chain (
        .clk  (clk),
        .nrst (nrst),
        .i_d  (bus.gray_in),
        .o_q  (w_gray_sync)
    );

    assign w_bin       = WIDTH'(gray_to_bin(32'(w_gray_sync), Mask));
    assign w_prev_bin  = WIDTH'(gray_to_bin(32'(r_prev_q), Mask));
    assign w_diff_bits = popcount(32'(w_gray_sync ^ r_prev_q));

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_prev_d    = r_prev_q;
        w_delta_d   = '0;
        w_changed_d = 1'b0;
        w_err_d     = 1'b0;
        w_ready_d   = r_ready_q;
        unique case (r_state_q)
            StWarmup: begin
                // Seed the reference sample once the chain has flushed out pre-reset data.
                if (r_cnt_q == CntW'(SYNC_STAGES)) begin
                    w_prev_d  = w_gray_sync;
                    w_state_d = StRun;
                end else begin
                    w_cnt_d = r_cnt_q + CntW'(1);
                end
            end
            StRun: begin
                w_ready_d = 1'b1;
                if (w_gray_sync != r_prev_q) begin
                    w_changed_d = 1'b1;
                    w_delta_d   = w_bin - w_prev_bin;
                    w_prev_d    = w_gray_sync;
                    w_err_d     = (w_diff_bits > 6'd1);
                end
            end
            default: w_state_d = StWarmup;
        endcase
        // A new error takes priority over a simultaneous clear.
        w_sticky_d = w_err_d | (r_sticky_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state_q   <= StWarmup;
            r_cnt_q     <= '0;
            r_prev_q    <= '0;
            r_bin_q     <= '0;
            r_delta_q   <= '0;
            r_changed_q <= 1'b0;
            r_err_q     <= 1'b0;
            r_sticky_q  <= 1'b0;
            r_ready_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_prev_q    <= w_prev_d;
            r_bin_q     <= w_bin;
            r_delta_q   <= w_delta_d;
            r_changed_q <= w_changed_d;
            r_err_q     <= w_err_d;
            r_sticky_q  <= w_sticky_d;
            r_ready_q   <= w_ready_d;
        end
    end

    assign bus.gray_sync    = w_gray_sync;
    assign bus.bin_out      = r_bin_q;
    assign bus.delta        = r_delta_q;
    assign bus.changed      = r_changed_q;
    assign bus.err_multibit = r_err_q;
    assign bus.err_sticky   = r_sticky_q;
    assign bus.ready        = r_ready_q;

endmodule

// File: tb/tb_gray_sync_rx.sv
// Directed bench for gray_sync_rx at WIDTH=8, SYNC_STAGES=2.
module tb_gray_sync_rx;

    logic clk;
    logic nrst;
    int   n_pass;
    int   n_total;

    gray_sync_rx_if #(.WIDTH(8)) bus ();

    gray_sync_rx #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] g);
        bus.gray_in = g;
        bus.err_clr = 1'b0;
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        bus.gray_in = 8'h00;
        bus.err_clr = 1'b0;
        nrst = 1'b0;
        #1;
        n_total++;
        if ({bus.gray_sync, bus.bin_out, bus.delta} !== 24'h0) begin
            $display("FAIL reset_values got %h/%h/%h exp 0", bus.gray_sync, bus.bin_out, bus.delta);
        end else n_pass++;
        n_total++;
        if ({bus.changed, bus.err_multibit, bus.err_sticky, bus.ready} !== 4'b0) begin
            $display("FAIL reset_flags got %b%b%b%b exp 0000", bus.changed, bus.err_multibit,
                     bus.err_sticky, bus.ready);
        end else n_pass++;
        tick();
        tick();
        nrst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_total++;
            if (bus.ready !== (k >= 4)) begin
                $display("FAIL reset_ready clk=%0d got %b exp %b", k, bus.ready, (k >= 4));
            end else n_pass++;
            n_total++;
            if ({bus.changed, bus.err_multibit, bus.err_sticky} !== 3'b0 || bus.bin_out !== 8'h00) begin
                $display("FAIL reset_quiet clk=%0d got chg=%b err=%b sticky=%b bin=%h exp 0",
                         k, bus.changed, bus.err_multibit, bus.err_sticky, bus.bin_out);
            end else n_pass++;
        end
    endtask

    task automatic test_warm_5a();
        do_reset(8'h5A);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_total++;
            if (bus.bin_out !== ((k >= 3) ? 8'h6C : 8'h00)) begin
                $display("FAIL warm_bin clk=%0d got %h exp %h", k, bus.bin_out,
                         (k >= 3) ? 8'h6C : 8'h00);
            end else n_pass++;
            n_total++;
            if (bus.changed !== 1'b0 || bus.err_multibit !== 1'b0) begin
                $display("FAIL warm_quiet clk=%0d got chg=%b err=%b exp 0 0", k, bus.changed,
                         bus.err_multibit);
            end else n_pass++;
            n_total++;
            if (bus.ready !== (k >= 4)) begin
                $display("FAIL warm_ready clk=%0d got %b exp %b", k, bus.ready, (k >= 4));
            end else n_pass++;
        end
    endtask

    task automatic test_count();
        int         n_chg;
        logic [7:0] v8;
        n_chg = 0;
        do_reset(8'h00);
        repeat (6) tick();
        for (int v = 1; v <= 10; v++) begin
            v8 = 8'(v);
            bus.gray_in = v8 ^ (v8 >> 1);
            for (int k = 1; k <= 3; k++) begin
                tick();
                if (bus.changed === 1'b1) n_chg++;
                n_total++;
                if (bus.bin_out !== ((k == 3) ? v8 : v8 - 8'd1)) begin
                    $display("FAIL count_bin v=%0d clk=%0d got %h exp %h", v, k, bus.bin_out,
                             (k == 3) ? v8 : v8 - 8'd1);
                end else n_pass++;
                n_total++;
                if (bus.changed !== (k == 3)) begin
                    $display("FAIL count_changed v=%0d clk=%0d got %b exp %b", v, k,
                             bus.changed, (k == 3));
                end else n_pass++;
                if (k == 3) begin
                    n_total++;
                    if (bus.delta !== 8'h01 || bus.err_multibit !== 1'b0) begin
                        $display("FAIL count_delta v=%0d got delta=%h err=%b exp 01 0", v,
                                 bus.delta, bus.err_multibit);
                    end else n_pass++;
                end
            end
        end
        n_total++;
        if (n_chg != 10 || bus.err_sticky !== 1'b0) begin
            $display("FAIL count_total got %0d sticky=%b exp 10 0", n_chg, bus.err_sticky);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset(8'h80);
        repeat (6) tick();
        n_total++;
        if (bus.bin_out !== 8'hFF || bus.ready !== 1'b1) begin
            $display("FAIL wrap_start got bin=%h ready=%b exp ff 1", bus.bin_out, bus.ready);
        end else n_pass++;
        bus.gray_in = 8'h00;
        repeat (3) tick();
        n_total++;
        if (bus.changed !== 1'b1 || bus.delta !== 8'h01 || bus.err_multibit !== 1'b0
            || bus.bin_out !== 8'h00) begin
            $display("FAIL wrap_step got chg=%b delta=%h err=%b bin=%h exp 1 01 0 00",
                     bus.changed, bus.delta, bus.err_multibit, bus.bin_out);
        end else n_pass++;
    endtask

    task automatic test_error();
        bus.gray_in = 8'h03;
        repeat (3) tick();
        n_total++;
        if (bus.err_multibit !== 1'b1 || bus.err_sticky !== 1'b1) begin
            $display("FAIL err_set got err=%b sticky=%b exp 1 1", bus.err_multibit, bus.err_sticky);
        end else n_pass++;
        n_total++;
        if (bus.bin_out !== 8'h02 || bus.delta !== 8'h02 || bus.changed !== 1'b1) begin
            $display("FAIL err_values got bin=%h delta=%h chg=%b exp 02 02 1", bus.bin_out,
                     bus.delta, bus.changed);
        end else n_pass++;
        tick();
        n_total++;
        if (bus.err_multibit !== 1'b0 || bus.err_sticky !== 1'b1) begin
            $display("FAIL err_pulse got err=%b sticky=%b exp 0 1", bus.err_multibit,
                     bus.err_sticky);
        end else n_pass++;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_total++;
        if (bus.err_sticky !== 1'b0) begin
            $display("FAIL err_clear got %b exp 0", bus.err_sticky);
        end else n_pass++;
        // Clear arrives in the same cycle as a fresh error: 0x03 -> 0x00 is a two-bit jump.
        bus.gray_in = 8'h00;
        tick();
        tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_total++;
        if (bus.err_multibit !== 1'b1 || bus.err_sticky !== 1'b1) begin
            $display("FAIL err_set_wins got err=%b sticky=%b exp 1 1", bus.err_multibit,
                     bus.err_sticky);
        end else n_pass++;
        n_total++;
        if (bus.delta !== 8'hFE || bus.bin_out !== 8'h00) begin
            $display("FAIL err_back got delta=%h bin=%h exp fe 00", bus.delta, bus.bin_out);
        end else n_pass++;
        tick();
        n_total++;
        if (bus.err_sticky !== 1'b1 || bus.err_multibit !== 1'b0) begin
            $display("FAIL err_hold got sticky=%b err=%b exp 1 0", bus.err_sticky,
                     bus.err_multibit);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.gray_in = 8'h33;
        tick();
        nrst = 1'b0;
        #1;
        n_total++;
        if ({bus.gray_sync, bus.bin_out, bus.delta} !== 24'h0) begin
            $display("FAIL mid_values got %h/%h/%h exp 0", bus.gray_sync, bus.bin_out, bus.delta);
        end else n_pass++;
        n_total++;
        if ({bus.changed, bus.err_multibit, bus.err_sticky, bus.ready} !== 4'b0) begin
            $display("FAIL mid_flags got %b%b%b%b exp 0000", bus.changed, bus.err_multibit,
                     bus.err_sticky, bus.ready);
        end else n_pass++;
        tick();
        tick();
        nrst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_total++;
            if (bus.ready !== (k >= 4)) begin
                $display("FAIL mid_ready clk=%0d got %b exp %b", k, bus.ready, (k >= 4));
            end else n_pass++;
            n_total++;
            if ({bus.changed, bus.err_multibit, bus.err_sticky} !== 3'b0) begin
                $display("FAIL mid_quiet clk=%0d got chg=%b err=%b sticky=%b exp 0", k,
                         bus.changed, bus.err_multibit, bus.err_sticky);
            end else n_pass++;
            if (k >= 3) begin
                n_total++;
                if (bus.bin_out !== 8'h22) begin
                    $display("FAIL mid_bin clk=%0d got %h exp 22", k, bus.bin_out);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        nrst    = 1'b0;
        bus.gray_in = 8'h00;
        bus.err_clr = 1'b0;
        test_reset();
        test_warm_5a();
        test_count();
        test_wrap();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
